// File: rtl/perf_sample_ctrl_if.sv
// perf_sample_ctrl_if: groups the core CSR port, the shared perf_counters port and the sample stream.
// Latency: wires only, no state.
// Backpressure: smp_ready is the only flow-control signal; core_gnt always equals core_req.
// Ports: slave = the sampler's view; master = the surrounding core/counter/sink view.
interface perf_sample_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  // core CSR request/response
  logic                  core_req;
  logic [11:0]           core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic [1:0]            core_op;
  logic                  core_gnt;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic                  core_rvalid;
  // shared CSR port towards perf_counters
  logic [11:0]           pc_addr;
  logic [DATA_WIDTH-1:0] pc_wdata;
  logic [1:0]            pc_op;
  logic [DATA_WIDTH-1:0] pc_rdata;
  logic                  pc_valid;
  // sample stream
  logic                  smp_valid;
  logic [DATA_WIDTH-1:0] smp_data;
  logic [4:0]            smp_idx;
  logic                  smp_last;
  logic                  smp_ready;

  modport slave (
    input  core_req, core_addr, core_wdata, core_op,
    output core_gnt, core_rdata, core_rvalid,
    output pc_addr, pc_wdata, pc_op,
    input  pc_rdata, pc_valid,
    output smp_valid, smp_data, smp_idx, smp_last,
    input  smp_ready
  );

  modport master (
    output core_req, core_addr, core_wdata, core_op,
    input  core_gnt, core_rdata, core_rvalid,
    input  pc_addr, pc_wdata, pc_op,
    output pc_rdata, pc_valid,
    input  smp_valid, smp_data, smp_idx, smp_last,
    output smp_ready
  );
endinterface

// File: rtl/perf_sample_ctrl.sv
// perf_sample_fifo: generic registered FIFO, output taken straight from the head register (first-word-fall-through).
// Latency: a pushed entry is visible at the output the cycle after the push; no push-to-pop bypass.
// Backpressure: full_o tells the writer to hold off; pushes while full are ignored.
// Ports: clk/rst_n; push_vld_i/push_dat_i write side; pop_rdy_i/pop_vld_o/pop_dat_o read side; full_o.
module perf_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_rdy_i,
  output logic             pop_vld_o,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;

  assign pop_vld_o = (count_q != '0);
  assign full_o    = (count_q == CW'(DEPTH));
  assign push      = push_vld_i & ~full_o;
  assign pop       = pop_vld_o & pop_rdy_i;
  assign pop_dat_o = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

// perf_sample_ctrl: periodic sweep of the perf CSRs B00..B1F selected by cfg_mask into a sample FIFO; core traffic always wins the shared CSR port.
// Latency: tick at T -> first read at T+1 -> sample visible at T+2; core access answered (core_rvalid) one cycle after grant.
// Backpressure: smp_ready low fills the FIFO and stalls the sweep; core_req stalls the sweep; a tick landing mid-sweep sets sticky overrun.
// Ports: clk/rst_n; bus (core req/rsp, pc CSR port, sample stream); cfg_enable/cfg_period/cfg_mask; ovr_clr; overrun; busy.
module perf_sample_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  perf_sample_ctrl_if.slave        bus,
  input  logic                     cfg_enable,
  input  logic [31:0]              cfg_period,
  input  logic [31:0]              cfg_mask,
  input  logic                     ovr_clr,
  output logic                     overrun,
  output logic                     busy
);
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // sample entry layout: {data, idx, last}
  localparam int SW = DATA_WIDTH + 6;

  state_t                state_q, state_d;
  logic [31:0]           tmr_q, tmr_d;
  logic [31:0]           pend_q, pend_d;
  logic                  ovr_q, ovr_d;
  logic                  rvld_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  tmr_run;
  logic                  tick;
  logic                  rd_en;
  logic                  rd_last;
  logic [4:0]            rd_idx;
  logic                  fifo_full;
  logic [SW-1:0]         push_dat;
  logic [SW-1:0]         pop_dat;
  logic                  smp_vld;

  // Interval timer. ">=" rather than "==" so that shrinking cfg_period under a
  // running count wraps at once instead of running out to 2^32.
  assign tmr_run = cfg_enable && (cfg_period != 32'd0);
  assign tick    = tmr_run && (tmr_q >= (cfg_period - 32'd1));
  assign tmr_d   = (!tmr_run || tick) ? 32'd0 : (tmr_q + 32'd1);

  // Lowest pending index; it is also the highest when clearing it empties the mask.
  always_comb begin
    rd_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pend_q[i]) rd_idx = 5'(i);
    end
  end
  assign rd_last = ((pend_q & (pend_q - 32'd1)) == 32'd0);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rd_en   = 1'b0;
    ovr_d   = ovr_q & ~ovr_clr;
    case (state_q)
      IDLE: begin
        if (tick && (cfg_mask != 32'd0)) begin
          state_d = SWEEP;
          pend_d  = cfg_mask;
        end
      end
      SWEEP: begin
        // a tick that arrives mid-sweep is dropped but remembered as overrun
        if (tick) ovr_d = 1'b1;
        if (!cfg_enable) begin
          state_d = IDLE;
          pend_d  = 32'd0;
        end else if (!bus.core_req && !fifo_full) begin
          rd_en  = 1'b1;
          pend_d = pend_q & (pend_q - 32'd1);
          if (rd_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= 32'd0;
      pend_q  <= 32'd0;
      ovr_q   <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      rvld_q  <= bus.core_req;
      if (bus.core_req) rdata_q <= bus.pc_rdata;
    end
  end

  // Shared CSR port: core first, then sampler read, otherwise a quiet read of 000.
  always_comb begin
    bus.pc_addr  = 12'h000;
    bus.pc_wdata = '0;
    bus.pc_op    = 2'b00;
    if (bus.core_req) begin
      bus.pc_addr  = bus.core_addr;
      bus.pc_wdata = bus.core_wdata;
      bus.pc_op    = bus.core_op;
    end else if (rd_en) begin
      bus.pc_addr  = 12'hB00 | {7'd0, rd_idx};
    end
  end

  assign push_dat = {(bus.pc_valid ? bus.pc_rdata : {DATA_WIDTH{1'b0}}), rd_idx, rd_last};

  perf_sample_fifo #(
    .WIDTH (SW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_vld_i (rd_en),
    .push_dat_i (push_dat),
    .pop_rdy_i  (bus.smp_ready),
    .pop_vld_o  (smp_vld),
    .pop_dat_o  (pop_dat),
    .full_o     (fifo_full)
  );

  assign bus.core_gnt    = bus.core_req;
  assign bus.core_rvalid = rvld_q;
  assign bus.core_rdata  = rdata_q;
  assign bus.smp_valid   = smp_vld;
  assign bus.smp_data    = pop_dat[SW-1:6];
  assign bus.smp_idx     = pop_dat[5:1];
  assign bus.smp_last    = pop_dat[0];
  assign overrun         = ovr_q;
  assign busy            = (state_q == SWEEP);
endmodule
